imm_extend_pipe: RTL and testbench

- Parametrised, pipelined immediate-generation stage for the multi-cycle/pipelined datapath.
- Widens an IN_W-bit instruction immediate to OUT_W bits using one of four modes: zero, sign, upper/LUI, or branch offset.
- Sits between decode and execute, with a valid/ready handshake on both sides.
- A 2-entry skid buffer gives full throughput under backpressure and carries a destination-register tag with each result.

---
 rtl/imm_extend_pipe_pkg.sv | 22 ++
 rtl/imm_extend_core.sv | 34 +++
 rtl/imm_extend_pipe.sv | 126 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// rtl/imm_extend_pipe_pkg.sv - shared types and width defaults for the immediate extend pipe
// Purpose: immediate mode encoding, skid buffer state encoding, default widths.
// Ports: none (package).
package imm_extend_pipe_pkg;

   localparam int IMM_IN_W  = 16;
   localparam int IMM_OUT_W = 32;

   typedef enum logic [1:0] {
      MODE_ZERO   = 2'b00,
      MODE_SIGN   = 2'b01,
      MODE_UPPER  = 2'b10,
      MODE_BRANCH = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      FULL  = 2'b10
   } state_t;

endpackage

// File: rtl/imm_extend_core.sv
// rtl/imm_extend_core.sv - combinational immediate widening for the four extend modes
// Purpose: widen an IN_W-bit immediate to OUT_W bits (zero, sign, upper, branch).
// Ports:
//   imm  in  IN_W   raw immediate
//   mode in  mode_t extend mode
//   ext  out OUT_W  widened immediate
module imm_extend_core
   import imm_extend_pipe_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W
) (
   input  logic [IN_W-1:0]  imm,
   input  mode_t            mode,
   output logic [OUT_W-1:0] ext
);

   logic [OUT_W-1:0] sext;

   assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

   always_comb begin
      ext = '0;
      case (mode)
         MODE_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
         MODE_SIGN:   ext = sext;
         MODE_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
         // word-aligned branch offset: the two MSBs shifted out are dropped
         MODE_BRANCH: ext = sext << 2;
         default:     ext = '0;
      endcase
   end

endmodule

// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - pipelined immediate extend stage with 2-entry skid buffer
// Purpose: accept an immediate plus tag, widen it, and present it downstream with
//          full throughput under backpressure. Optional macro IMM_EXT_STATS_EN adds
//          a saturating output-transfer counter.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready           upstream handshake (in_ready registered)
//   in_imm, in_mode, in_tag     immediate, extend mode, sideband tag
//   out_valid/out_ready         downstream handshake
//   out_imm, out_tag, out_neg   result, matching tag, result MSB
//   xfer_cnt                    (IMM_EXT_STATS_EN only) saturating output transfer count
module imm_extend_pipe
   import imm_extend_pipe_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W,
   parameter int TAG_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_imm,
   input  logic [1:0]        in_mode,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_imm,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_neg
`ifdef IMM_EXT_STATS_EN
   ,
   output logic [15:0]       xfer_cnt
`endif
);

   logic [OUT_W-1:0] ext_imm;
   logic [OUT_W-1:0] skid_imm;
   logic [TAG_W-1:0] skid_tag;
   logic             in_xfer;
   logic             out_xfer;
   state_t           state;

   imm_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm  (in_imm),
      .mode (mode_t'(in_mode)),
      .ext  (ext_imm)
   );

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // in_ready and out_valid are registered copies of (state != FULL) and
   // (state != EMPTY), updated alongside the state so neither has a
   // combinational path from out_ready.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_imm   <= '0;
         out_tag   <= '0;
         out_neg   <= 1'b0;
         skid_imm  <= '0;
         skid_tag  <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  out_imm   <= ext_imm;
                  out_tag   <= in_tag;
                  out_neg   <= ext_imm[OUT_W-1];
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  // current result leaves while the new one takes its place
                  out_imm <= ext_imm;
                  out_tag <= in_tag;
                  out_neg <= ext_imm[OUT_W-1];
               end else if (in_xfer) begin
                  skid_imm <= ext_imm;
                  skid_tag <= in_tag;
                  in_ready <= 1'b0;
                  state    <= FULL;
               end else if (out_xfer) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  out_imm  <= skid_imm;
                  out_tag  <= skid_tag;
                  out_neg  <= skid_imm[OUT_W-1];
                  skid_imm <= '0;
                  skid_tag <= '0;
                  in_ready <= 1'b1;
                  state    <= ONE;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef IMM_EXT_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (out_xfer && (xfer_cnt != 16'hFFFF)) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - scoreboard testbench for imm_extend_pipe
module tb_imm_extend_pipe;

   typedef struct {
      logic [31:0] imm;
      logic [4:0]  tag;
      int          acc_cyc;
      bit          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [4:0]  out_tag;
   logic        out_neg;
`ifdef IMM_EXT_STATS_EN
   logic [15:0] xfer_cnt;
`endif

   exp_t        sb[$];
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] held_imm;

   imm_extend_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_imm    (in_imm),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_imm   (out_imm),
      .out_tag   (out_tag),
      .out_neg   (out_neg)
`ifdef IMM_EXT_STATS_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Drive one input and hold it until accepted; the expected result is queued
   // with the cycle in which it must first appear at the output.
   task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag,
                       input logic [31:0] exp, input bit lat);
      exp_t e;
      int   w;
      in_imm   = imm;
      in_mode  = mode;
      in_tag   = tag;
      in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: tag %0d not accepted in %0d cycles", tag, w);
         in_valid = 1'b0;
      end else begin
         e.imm = exp; e.tag = tag; e.acc_cyc = cyc + 1; e.lat = lat;
         sb.push_back(e);
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Monitor: every output transfer is matched against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out: tag %0d imm %h with empty scoreboard", out_tag, out_imm);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
            chk("out_imm", out_imm, e.imm);
            chk("out_neg", {31'd0, out_neg}, {31'd0, e.imm[31]});
            if (e.lat) chk("latency", cyc, e.acc_cyc);
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; in_tag = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_imm", out_imm, 32'd0);
      chk("rst_out_tag", {27'd0, out_tag}, 32'd0);
      chk("rst_out_neg", {31'd0, out_neg}, 32'd0);

      // mode arithmetic
      out_ready = 1'b1;
      send(16'h8001, 2'b00, 5'd1, 32'h00008001, 1);
      send(16'h8001, 2'b01, 5'd2, 32'hFFFF8001, 1);
      send(16'h8001, 2'b10, 5'd3, 32'h80010000, 1);
      send(16'hFFFF, 2'b11, 5'd4, 32'hFFFFFFFC, 1);
      send(16'h7FFF, 2'b01, 5'd5, 32'h00007FFF, 1);
      send(16'h0001, 2'b11, 5'd6, 32'h00000004, 1);
      send(16'h8000, 2'b11, 5'd7, 32'hFFFE0000, 1);
      send(16'hFFFF, 2'b00, 5'd8, 32'h0000FFFF, 1);
      idle(3);

      // back-to-back throughput, tags 0..7
      for (int i = 0; i < 8; i++) begin
         logic [15:0] v;
         v = 16'h1000 + 16'(i);
         send(v, 2'b00, 5'(i), {16'h0000, v}, 1);
         chk("tput_in_ready", {31'd0, in_ready}, 32'd1);
      end
      idle(3);

      // backpressure
      out_ready = 1'b0;
      send(16'h0011, 2'b00, 5'd1, 32'h00000011, 0);
      send(16'h0022, 2'b00, 5'd2, 32'h00000022, 0);
      chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      held_imm = out_imm;
      in_imm = 16'h0033; in_mode = 2'b00; in_tag = 5'd3; in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_tag", {27'd0, out_tag}, 32'd1);
         chk("bp_hold_imm", out_imm, held_imm);
      end
      out_ready = 1'b1;
      send(16'h0033, 2'b00, 5'd3, 32'h00000033, 1);
      idle(4);

      // simultaneous in/out in ONE
      out_ready = 1'b0;
      send(16'h0044, 2'b00, 5'd4, 32'h00000044, 1);
      out_ready = 1'b1;
      send(16'h0055, 2'b01, 5'd5, 32'h00000055, 1);
      in_valid = 1'b0;
      chk("sim_tag", {27'd0, out_tag}, 32'd5);
      chk("sim_valid", {31'd0, out_valid}, 32'd1);
      chk("sim_in_ready", {31'd0, in_ready}, 32'd1);
      idle(3);

      // reset while FULL
      out_ready = 1'b0;
      send(16'h0066, 2'b00, 5'd6, 32'h00000066, 0);
      send(16'h8077, 2'b01, 5'd7, 32'hFFFF8077, 0);
      in_valid = 1'b0;
      chk("full_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_out_imm", out_imm, 32'd0);
      chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mrst_out_tag", {27'd0, out_tag}, 32'd0);
      out_ready = 1'b1;
      idle(5);
      chk("mrst_no_stale", {31'd0, out_valid}, 32'd0);

`ifdef IMM_EXT_STATS_EN
      for (int i = 0; i < 70000; i++) begin
         send(16'h0001, 2'b00, 5'(i), 32'h00000001, 1);
      end
      idle(3);
      chk("cnt_saturated", {16'd0, xfer_cnt}, 32'h0000FFFF);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("cnt_reset", {16'd0, xfer_cnt}, 32'd0);
`endif

      begin
         int w;
         w = 0;
         while (sb.size() != 0 && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         chk("sb_drained", sb.size(), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
